bpred_update: RTL and testbench

- Resolve-side companion to the fetch-stage branch predictor.
- Owns the 512-entry 2-bit bimodal counter table and answers the predictor's per-cycle lookup with a registered taken bit.
- Accepts resolved-branch records from execute through a small queue. Retires each record with a 2-stage read-modify-write of the counter table, and writes taken targets into the predictor's BTB write port.
- Counts mispredictions for performance monitoring.

---
 rtl/bpred_update.sv | 208 ++++++++++++++++++++
 tb/tb_bpred_update.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpred_update.sv
// Resolve-side bimodal updater: counter table, update queue,
// two-stage read-modify-write pipe, BTB write port, mispredict count.
module bpred_update #(
  parameter int BIM_IDX_W  = 9,
  parameter int BTB_ADDR_W = 8,
  parameter int BTB_WORD_W = 32,
  parameter int Q_DEPTH    = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           lu_pc,
  output logic                  lu_taken,
  input  logic                  up_valid,
  output logic                  up_ready,
  input  logic [31:0]           up_pc,
  input  logic                  up_taken,
  input  logic                  up_pred,
  input  logic [31:0]           up_target,
  output logic                  btb_wren,
  output logic [BTB_ADDR_W-1:0] btb_waddr,
  output logic [BTB_WORD_W-1:0] btb_wdata,
  output logic                  init_done,
  output logic [CNT_W-1:0]      mispredict_cnt
);

  localparam int QP_W  = $clog2(Q_DEPTH);
  localparam int BIM_N = 1 << BIM_IDX_W;
  localparam logic [QP_W:0] Q_FULL =
    (QP_W+1)'(Q_DEPTH);
  localparam logic [CNT_W-1:0] MIS_MAX =
    {CNT_W{1'b1}};

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [BIM_IDX_W-1:0] sweep_q;
  logic [1:0]           tbl [BIM_N];

  logic [BIM_IDX_W-1:0]  q_bidx  [Q_DEPTH];
  logic [BTB_ADDR_W-1:0] q_baddr [Q_DEPTH];
  logic [29:0]           q_tgt   [Q_DEPTH];
  logic                  q_taken [Q_DEPTH];
  logic                  q_pred  [Q_DEPTH];

  logic [QP_W-1:0] wr_ptr;
  logic [QP_W-1:0] rd_ptr;
  logic [QP_W:0]   q_cnt;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  logic [BIM_IDX_W-1:0] u1_idx;
  logic [1:0]           u1_cnt;

  logic                 u2_valid;
  logic [BIM_IDX_W-1:0] u2_idx;
  logic [1:0]           u2_cnt;
  logic                 u2_taken;
  logic                 u2_pred;
  logic [1:0]           u2_new;

  logic [CNT_W-1:0] mis_q;
  logic             unused_bits;

  assign unused_bits = ^{lu_pc, up_pc, up_target[1:0]};

  assign init_done      = (state_q == S_RUN);
  assign full           = (q_cnt == Q_FULL);
  assign empty          = (q_cnt == '0);
  assign up_ready       = init_done && !full;
  assign push           = up_valid && up_ready;
  assign pop            = !empty;
  assign mispredict_cnt = mis_q;

  // Sweep finishes after the last table entry is written.
  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && sweep_q == '1) begin
      state_d = S_RUN;
    end
  end

  // FSM state and sweep index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) begin
        sweep_q <= sweep_q + 1'b1;
      end
    end
  end

  // Counter table: sweep initialisation, then U2 writes.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      tbl[sweep_q] <= 2'b01;
    end else if (u2_valid) begin
      tbl[u2_idx] <= u2_new;
    end
  end

  // Registered lookup; sees the table before this cycle's write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_taken <= 1'b0;
    end else if (state_q == S_RUN) begin
      lu_taken <= tbl[lu_pc[BIM_IDX_W+1:2]][1];
    end else begin
      lu_taken <= 1'b0;
    end
  end

  // Queue storage; only the fields the pipe needs are kept.
  always_ff @(posedge clk) begin
    if (push) begin
      q_bidx[wr_ptr]  <= up_pc[BIM_IDX_W+1:2];
      q_baddr[wr_ptr] <= up_pc[BTB_ADDR_W+1:2];
      q_tgt[wr_ptr]   <= up_target[31:2];
      q_taken[wr_ptr] <= up_taken;
      q_pred[wr_ptr]  <= up_pred;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   q_cnt <= q_cnt + 1'b1;
        2'b01:   q_cnt <= q_cnt - 1'b1;
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // U1 read with bypass of the value U2 is writing.
  always_comb begin
    u1_idx = q_bidx[rd_ptr];
    u1_cnt = tbl[u1_idx];
    if (u2_valid && u2_idx == u1_idx) begin
      u1_cnt = u2_new;
    end
  end

  // U2 saturating counter step.
  always_comb begin
    u2_new = u2_cnt;
    if (u2_taken) begin
      if (u2_cnt != 2'b11) u2_new = u2_cnt + 2'b01;
    end else begin
      if (u2_cnt != 2'b00) u2_new = u2_cnt - 2'b01;
    end
  end

  // U1 -> U2 register plus BTB write port for the U2 cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u2_valid  <= 1'b0;
      u2_idx    <= '0;
      u2_cnt    <= '0;
      u2_taken  <= 1'b0;
      u2_pred   <= 1'b0;
      btb_wren  <= 1'b0;
      btb_waddr <= '0;
      btb_wdata <= '0;
    end else begin
      u2_valid <= pop;
      btb_wren <= pop && q_taken[rd_ptr];
      if (pop) begin
        u2_idx   <= u1_idx;
        u2_cnt   <= u1_cnt;
        u2_taken <= q_taken[rd_ptr];
        u2_pred  <= q_pred[rd_ptr];
      end
      if (pop && q_taken[rd_ptr]) begin
        btb_waddr <= q_baddr[rd_ptr];
        btb_wdata <=
          BTB_WORD_W'({2'b00, q_tgt[rd_ptr]});
      end
    end
  end

  // Saturating mispredict counter, bumped as U2 retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= '0;
    end else if (u2_valid && u2_taken != u2_pred
                 && mis_q != MIS_MAX) begin
      mis_q <= mis_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_bpred_update.sv
// Directed bench for bpred_update: init sweep, counter updates,
// bypass, queue backpressure, mispredict count, mid-work reset.
module tb_bpred_update;

  logic        clk;
  logic        rst_n;
  logic [31:0] lu_pc;
  logic        lu_taken;
  logic        up_valid;
  logic        up_ready;
  logic [31:0] up_pc;
  logic        up_taken;
  logic        up_pred;
  logic [31:0] up_target;
  logic        btb_wren;
  logic [7:0]  btb_waddr;
  logic [31:0] btb_wdata;
  logic        init_done;
  logic [15:0] mispredict_cnt;

  int n_chk;
  int n_pass;
  logic [15:0] exp_mis;

  logic [7:0]  log_a [$];
  logic [31:0] log_d [$];

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        pred;
    logic [31:0] tgt;
    logic        exp_lu;
  } vec_t;

  vec_t vecs [10];

  bpred_update dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lu_pc          (lu_pc),
    .lu_taken       (lu_taken),
    .up_valid       (up_valid),
    .up_ready       (up_ready),
    .up_pc          (up_pc),
    .up_taken       (up_taken),
    .up_pred        (up_pred),
    .up_target      (up_target),
    .btb_wren       (btb_wren),
    .btb_waddr      (btb_waddr),
    .btb_wdata      (btb_wdata),
    .init_done      (init_done),
    .mispredict_cnt (mispredict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (rst_n && btb_wren) begin
      log_a.push_back(btb_waddr);
      log_d.push_back(btb_wdata);
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic push(input logic [31:0] pc,
                      input logic tk,
                      input logic pr,
                      input logic [31:0] tgt);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    up_valid  = 1'b1;
    up_pc     = pc;
    up_taken  = tk;
    up_pred   = pr;
    up_target = tgt;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (up_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("push_timeout", 32'd0, 32'd1);
    if (tk != pr) begin
      if (exp_mis != 16'hFFFF) exp_mis = exp_mis + 1'b1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    up_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic look(input logic [31:0] pc,
                      input logic exp);
    lu_pc = pc;
    @(posedge clk);
    #1;
    chk("lu_taken", {31'd0, lu_taken}, {31'd0, exp});
    @(negedge clk);
  endtask

  task automatic wait_init(input int want);
    int got;
    got = 0;
    for (int i = 1; i <= 600; i++) begin
      @(posedge clk);
      #1;
      if (init_done) begin
        got = i;
        break;
      end
    end
    chk("init_cycles", got, want);
  endtask

  initial begin
    int n0;
    logic bad;
    logic [31:0] pc;
    n_chk     = 0;
    n_pass    = 0;
    exp_mis   = '0;
    rst_n     = 1'b0;
    lu_pc     = 32'h40;
    up_valid  = 1'b0;
    up_pc     = '0;
    up_taken  = 1'b0;
    up_pred   = 1'b0;
    up_target = '0;

    vecs[0] = '{32'h40,  1'b1, 1'b0, 32'h100,  1'b1};
    vecs[1] = '{32'h40,  1'b1, 1'b1, 32'h100,  1'b1};
    vecs[2] = '{32'h40,  1'b0, 1'b1, 32'h100,  1'b1};
    vecs[3] = '{32'h40,  1'b0, 1'b1, 32'h100,  1'b0};
    vecs[4] = '{32'h40,  1'b0, 1'b0, 32'h100,  1'b0};
    vecs[5] = '{32'h40,  1'b0, 1'b0, 32'h100,  1'b0};
    vecs[6] = '{32'h40,  1'b1, 1'b0, 32'h100,  1'b0};
    vecs[7] = '{32'h40,  1'b1, 1'b0, 32'h100,  1'b1};
    vecs[8] = '{32'h80,  1'b1, 1'b1, 32'h2000, 1'b1};
    vecs[9] = '{32'h840, 1'b0, 1'b1, 32'h0,    1'b0};

    #1;
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_up_ready", {31'd0, up_ready}, 32'd0);
    chk("rst_btb_wren", {31'd0, btb_wren}, 32'd0);
    chk("rst_mis", {16'd0, mispredict_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    bad = 1'b0;
    for (int i = 0; i < 511; i++) begin
      @(posedge clk);
      #1;
      bad = bad | init_done | up_ready | lu_taken;
    end
    chk("init_quiet", {31'd0, bad}, 32'd0);
    @(posedge clk);
    #1;
    chk("init_done_512", {31'd0, init_done}, 32'd1);
    chk("ready_after_init", {31'd0, up_ready}, 32'd1);
    @(negedge clk);
    look(32'h0, 1'b0);
    look(32'h40, 1'b0);
    look(32'h7FC, 1'b0);

    for (int k = 0; k < 10; k++) begin
      n0 = log_a.size();
      push(vecs[k].pc, vecs[k].taken,
           vecs[k].pred, vecs[k].tgt);
      settle();
      look(vecs[k].pc, vecs[k].exp_lu);
      chk("btb_writes", log_a.size() - n0,
          {31'd0, vecs[k].taken});
      if (vecs[k].taken && log_a.size() > n0) begin
        pc = vecs[k].pc;
        chk("btb_waddr", {24'd0, log_a[n0]},
            {24'd0, pc[9:2]});
        chk("btb_wdata", log_d[n0],
            {2'b00, vecs[k].tgt[31:2]});
      end
      chk("mis_cnt", {16'd0, mispredict_cnt},
          {16'd0, exp_mis});
    end

    n0 = log_a.size();
    push(32'h300, 1'b1, 1'b1, 32'h3000);
    push(32'h300, 1'b1, 1'b1, 32'h3000);
    settle();
    push(32'h300, 1'b0, 1'b1, 32'h0);
    settle();
    look(32'h300, 1'b1);
    chk("bypass_btb", log_a.size() - n0, 32'd2);

    n0 = log_a.size();
    @(negedge clk);
    force dut.pop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push(32'h400 + 4 * k, 1'b1, 1'b1,
           32'h1000 + 16 * k);
    end
    @(negedge clk);
    up_pc     = 32'h410;
    up_target = 32'h1040;
    #1;
    chk("full_not_ready", {31'd0, up_ready}, 32'd0);
    repeat (3) @(negedge clk);
    release dut.pop;
    push(32'h410, 1'b1, 1'b1, 32'h1040);
    settle();
    repeat (4) @(negedge clk);
    chk("stall_count", log_a.size() - n0, 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (log_a.size() > n0 + k) begin
        chk("stall_addr", {24'd0, log_a[n0+k]}, k);
        chk("stall_data", log_d[n0+k],
            32'h400 + 4 * k);
      end
    end

    @(negedge clk);
    force dut.pop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push(32'h600 + 4 * k, 1'b1, 1'b0, 32'h80);
    end
    @(negedge clk);
    up_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, up_ready}, 32'd0);
    chk("mid_rst_done", {31'd0, init_done}, 32'd0);
    chk("mid_rst_wren", {31'd0, btb_wren}, 32'd0);
    chk("mid_rst_waddr", {24'd0, btb_waddr}, 32'd0);
    chk("mid_rst_wdata", btb_wdata, 32'd0);
    chk("mid_rst_mis", {16'd0, mispredict_cnt}, 32'd0);
    chk("mid_rst_lu", {31'd0, lu_taken}, 32'd0);
    exp_mis = '0;
    release dut.pop;
    n0 = log_a.size();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_init(512);
    repeat (4) @(negedge clk);
    chk("no_wren_after_rst", log_a.size() - n0, 32'd0);
    look(32'h600, 1'b0);

    push(32'h500, 1'b0, 1'b1, 32'h0);
    push(32'h504, 1'b0, 1'b0, 32'h0);
    push(32'h508, 1'b0, 1'b1, 32'h0);
    push(32'h50C, 1'b0, 1'b0, 32'h0);
    push(32'h510, 1'b0, 1'b1, 32'h0);
    settle();
    chk("mis_three", {16'd0, mispredict_cnt}, 32'd3);

    @(negedge clk);
    force dut.mis_q = 16'hFFFD;
    #1;
    release dut.mis_q;
    exp_mis = 16'hFFFD;
    for (int k = 0; k < 3; k++) begin
      push(32'h520, 1'b0, 1'b1, 32'h0);
    end
    settle();
    chk("mis_sat", {16'd0, mispredict_cnt},
        {16'd0, exp_mis});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
